// File: rtl/swervolf_sseg_pkg.sv
// rtl/swervolf_sseg_pkg.sv - shared types and constants for the seven-segment scanner
package swervolf_sseg_pkg;

  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Segment bit positions inside a 7-bit glyph
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Hex glyphs in logical polarity (1 = segment lit), b and d lower-case
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/swervolf_sseg_if.sv
// rtl/swervolf_sseg_if.sv - display data in / scan drive out bundle
interface swervolf_sseg_if;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic [3:0]  i_en;
  logic        i_lzb;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  modport master (
    output i_data, i_dp, i_en, i_lzb,
    input  o_an, o_seg, o_dp
  );

  modport slave (
    input  i_data, i_dp, i_en, i_lzb,
    output o_an, o_seg, o_dp
  );
endinterface

// File: rtl/swervolf_sseg_hex_decode.sv
// rtl/swervolf_sseg_hex_decode.sv - combinational hex nibble to segment glyph
module sseg_hex_decode
  import swervolf_sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/swervolf_sseg.sv
// rtl/swervolf_sseg.sv - four-digit multiplexed seven-segment scanner
module swervolf_sseg
  import swervolf_sseg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 25_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input logic             clk,
  input logic             rst,
  swervolf_sseg_if.slave  bus
);

  localparam int DIV = CLK_FREQ_HZ / DIGIT_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV <= BLANK_CYCLES + 1) begin : g_bad_div
    $error("swervolf_sseg: DIV must exceed BLANK_CYCLES + 1");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          wrap;
  logic [1:0]    idx;
  state_t        state;

  logic [15:0]   sh_data;
  logic [3:0]    sh_dp;
  logic [3:0]    sh_en;
  logic          sh_lzb;

  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          lz_blank;
  logic          lit;

  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  assign wrap     = (cnt == CW'(DIV - 1));
  assign cnt_next = wrap ? '0 : cnt + 1'b1;

  // Prescaler, digit index, scan state and per-frame shadow capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      state   <= ST_BLANK;
      sh_data <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
      sh_lzb  <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      if (wrap) idx <= idx + 2'd1;
      state <= (cnt_next < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_ACTIVE;
      // First clock of the digit-0 slot (also right after reset): still
      // inside the blank window, so the frame never shows a mixed value.
      if (cnt == '0 && idx == 2'd0) begin
        sh_data <= bus.i_data;
        sh_dp   <= bus.i_dp;
        sh_en   <= bus.i_en;
        sh_lzb  <= bus.i_lzb;
      end
    end
  end

  assign nib = sh_data[{idx, 2'b00} +: 4];

  sseg_hex_decode u_decode (
    .nibble (nib),
    .seg    (glyph)
  );

  // Leading-zero blanking: digit n goes dark when nibbles n..3 are all zero
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd1:    lz_blank = (sh_data[15:4]  == 12'h000);
      2'd2:    lz_blank = (sh_data[15:8]  == 8'h00);
      2'd3:    lz_blank = (sh_data[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank & sh_lzb;
  end

  assign lit = (state == ST_ACTIVE) && sh_en[idx] && !lz_blank;

  // Output register in logical polarity, one clock behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r  <= 4'h0;
      seg_r <= 7'h00;
      dp_r  <= 1'b0;
    end else begin
      an_r  <= lit ? (4'b0001 << idx) : 4'h0;
      seg_r <= lit ? glyph : 7'h00;
      dp_r  <= lit & sh_dp[idx];
    end
  end

  assign bus.o_an  = (ACTIVE_LOW != 0) ? ~an_r  : an_r;
  assign bus.o_seg = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;
  assign bus.o_dp  = (ACTIVE_LOW != 0) ? ~dp_r  : dp_r;

endmodule
